// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared types, init table and state encodings for codec_config_seq
//   NUM_REGS     : number of init table entries
//   seq_state_t  : frame-level sequencer states (top)
//   wr_state_t   : bus-phase states of the byte writer
//   i2c_op_t     : byte writer command opcodes
//   init_entry() : init table lookup, {addr[6:0], data[8:0]}
package codec_cfg_pkg;

    localparam logic [3:0] NUM_REGS = 4'd11;

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_NEXT
    } seq_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_START,
        W_BIT,
        W_ACK,
        W_STOP
    } wr_state_t;

    typedef enum logic [1:0] {
        OP_START,
        OP_BYTE,
        OP_STOP
    } i2c_op_t;

    // R15 (reset) goes first so the codec starts from a known register state.
    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        logic [15:0] e;
        case (idx)
            4'd0:    e = {7'h0F, 9'h000};
            4'd1:    e = {7'h00, 9'h017};
            4'd2:    e = {7'h01, 9'h017};
            4'd3:    e = {7'h02, 9'h079};
            4'd4:    e = {7'h03, 9'h079};
            4'd5:    e = {7'h04, 9'h012};
            4'd6:    e = {7'h05, 9'h000};
            4'd7:    e = {7'h06, 9'h000};
            4'd8:    e = {7'h07, 9'h001};
            4'd9:    e = {7'h08, 9'h000};
            4'd10:   e = {7'h09, 9'h001};
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/codec_config_seq_if.sv
// rtl/codec_config_seq_if.sv - control/request bundle between effects logic and codec_config_seq
//   start     : one-cycle pulse, re-run init table
//   wr_req    : runtime write request, held until wr_ack
//   wr_addr   : codec register address
//   wr_data   : codec register data
//   wr_ack    : one-cycle pulse, runtime write finished
//   busy      : table walk or transaction in progress
//   done      : init table completed
//   ack_error : sticky NACK flag
interface codec_config_seq_if;

    logic       start;
    logic       wr_req;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       wr_ack;
    logic       busy;
    logic       done;
    logic       ack_error;

    modport master (
        output start, wr_req, wr_addr, wr_data,
        input  wr_ack, busy, done, ack_error
    );

    modport slave (
        input  start, wr_req, wr_addr, wr_data,
        output wr_ack, busy, done, ack_error
    );

endinterface

// File: rtl/i2c_byte_writer.sv
// rtl/i2c_byte_writer.sv - quarter-bit timed I2C engine: START, one byte + ACK, or STOP + idle gap
//   clk, reset : clock, synchronous active-high reset
//   cmd_valid  : one-cycle command strobe, only issued while the engine is idle
//   cmd_op     : OP_START / OP_BYTE / OP_STOP
//   cmd_byte   : byte to shift out MSB first for OP_BYTE
//   cmd_done   : one-cycle pulse when the command's last quarter has elapsed
//   cmd_nack   : ACK bit sampled during the last OP_BYTE (1 = NACK)
//   scl        : I2C clock, idles high
//   sda        : open-drain data line, driven low or released
module i2c_byte_writer
    import codec_cfg_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  i2c_op_t    cmd_op,
    input  logic [7:0] cmd_byte,
    output logic       cmd_done,
    output logic       cmd_nack,
    output logic       scl,
    inout  wire        sda
);

    localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    wr_state_t        wstate;
    logic [2:0]       q;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             sda_low;

    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    // q counts quarters inside the current phase; STOP uses q4..q7 as the
    // mandatory bus-idle gap before the next frame may start.
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate   <= W_IDLE;
            q        <= 3'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            scl      <= 1'b1;
            sda_low  <= 1'b0;
            cmd_done <= 1'b0;
            cmd_nack <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            case (wstate)
                W_IDLE: begin
                    if (cmd_valid) begin
                        q       <= 3'd0;
                        bit_cnt <= 3'd0;
                        shreg   <= cmd_byte;
                        case (cmd_op)
                            OP_START: wstate <= W_START;
                            OP_BYTE:  wstate <= W_BIT;
                            default:  wstate <= W_STOP;
                        endcase
                    end
                end
                W_START: begin
                    if (tick) begin
                        if (q == 3'd0) begin
                            sda_low <= 1'b1;
                            q       <= 3'd1;
                        end else begin
                            scl      <= 1'b0;
                            q        <= 3'd0;
                            cmd_done <= 1'b1;
                            wstate   <= W_IDLE;
                        end
                    end
                end
                W_BIT: begin
                    if (tick) begin
                        q <= q + 3'd1;
                        case (q)
                            3'd0: sda_low <= ~shreg[7];
                            3'd1: scl <= 1'b1;
                            3'd3: begin
                                scl     <= 1'b0;
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                                q       <= 3'd0;
                                if (bit_cnt == 3'd7) begin
                                    wstate <= W_ACK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                W_ACK: begin
                    if (tick) begin
                        q <= q + 3'd1;
                        case (q)
                            3'd0: sda_low <= 1'b0;
                            3'd1: scl <= 1'b1;
                            3'd2: cmd_nack <= sda;
                            3'd3: begin
                                scl      <= 1'b0;
                                q        <= 3'd0;
                                cmd_done <= 1'b1;
                                wstate   <= W_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                W_STOP: begin
                    if (tick) begin
                        q <= q + 3'd1;
                        case (q)
                            3'd0: sda_low <= 1'b1;
                            3'd1: scl <= 1'b1;
                            3'd2: sda_low <= 1'b0;
                            3'd7: begin
                                q        <= 3'd0;
                                cmd_done <= 1'b1;
                                wstate   <= W_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/codec_config_seq.sv
// rtl/codec_config_seq.sv - WM8731 init table walker and runtime register writer over I2C
//   clk, reset : clock, synchronous active-high reset
//   cfg        : control/request bundle (start, wr_req/addr/data/ack, busy, done, ack_error)
//   I2C_SCLK   : I2C clock, idles high
//   I2C_SDAT   : open-drain I2C data
module codec_config_seq
    import codec_cfg_pkg::*;
#(
    parameter int          CLK_DIV      = 125,
    parameter logic [6:0]  DEV_ADDR     = 7'h1A,
    parameter logic [15:0] POWERUP_WAIT = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    codec_config_seq_if.slave  cfg,
    output logic               I2C_SCLK,
    inout  wire                I2C_SDAT
);

    seq_state_t  state;
    logic [15:0] pwr_cnt;
    logic [3:0]  tbl_idx;
    logic [15:0] frame;       // {addr[6:0], data[8:0]} of the frame in flight
    logic [1:0]  byte_idx;
    logic        walking;     // current frame belongs to the init table
    logic        issued;      // command for the current state already sent
    logic        start_pend;
    logic        nack_seen;

    logic        cmd_valid;
    i2c_op_t     cmd_op;
    logic [7:0]  cmd_byte;
    logic        cmd_done;
    logic        cmd_nack;
    logic [7:0]  cur_byte;

    always_comb begin
        cur_byte = frame[7:0];
        if (byte_idx == 2'd0) begin
            cur_byte = {DEV_ADDR, 1'b0};
        end else if (byte_idx == 2'd1) begin
            cur_byte = frame[15:8];
        end
    end

    i2c_byte_writer #(
        .CLK_DIV (CLK_DIV)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_byte  (cmd_byte),
        .cmd_done  (cmd_done),
        .cmd_nack  (cmd_nack),
        .scl       (I2C_SCLK),
        .sda       (I2C_SDAT)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_WAIT_PWR;
            pwr_cnt       <= POWERUP_WAIT;
            tbl_idx       <= 4'd0;
            frame         <= 16'h0000;
            byte_idx      <= 2'd0;
            walking       <= 1'b1;
            issued        <= 1'b0;
            start_pend    <= 1'b0;
            nack_seen     <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_op        <= OP_START;
            cmd_byte      <= 8'h00;
            cfg.busy      <= 1'b1;
            cfg.done      <= 1'b0;
            cfg.ack_error <= 1'b0;
            cfg.wr_ack    <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            cfg.wr_ack <= 1'b0;

            // start is remembered whenever it arrives; IDLE consumes it.
            if (cfg.start) begin
                start_pend    <= 1'b1;
                cfg.done      <= 1'b0;
                cfg.ack_error <= 1'b0;
            end

            case (state)
                S_WAIT_PWR: begin
                    if (pwr_cnt == 16'd0) begin
                        state <= S_NEXT;
                    end else begin
                        pwr_cnt <= pwr_cnt - 16'd1;
                    end
                end
                S_IDLE: begin
                    if (cfg.start || start_pend) begin
                        start_pend <= 1'b0;
                        tbl_idx    <= 4'd0;
                        walking    <= 1'b1;
                        cfg.busy   <= 1'b1;
                        cfg.done   <= 1'b0;
                        state      <= S_NEXT;
                    end else if (cfg.wr_req) begin
                        frame    <= {cfg.wr_addr, cfg.wr_data};
                        walking  <= 1'b0;
                        byte_idx <= 2'd0;
                        cfg.busy <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (!issued) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_START;
                        issued    <= 1'b1;
                    end else if (cmd_done) begin
                        issued <= 1'b0;
                        state  <= S_BIT;
                    end
                end
                S_BIT: begin
                    if (!issued) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_BYTE;
                        cmd_byte  <= cur_byte;
                        issued    <= 1'b1;
                    end else if (cmd_done) begin
                        issued    <= 1'b0;
                        nack_seen <= cmd_nack;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    // A NACK abandons the rest of the frame; the entry counts as done.
                    if (nack_seen) begin
                        cfg.ack_error <= 1'b1;
                        state         <= S_STOP;
                    end else if (byte_idx == 2'd2) begin
                        state <= S_STOP;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        state    <= S_BIT;
                    end
                end
                S_STOP: begin
                    if (!issued) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_STOP;
                        issued    <= 1'b1;
                    end else if (cmd_done) begin
                        issued <= 1'b0;
                        if (walking) begin
                            state <= S_NEXT;
                        end else begin
                            cfg.busy   <= 1'b0;
                            cfg.wr_ack <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_NEXT: begin
                    if (tbl_idx < NUM_REGS) begin
                        frame    <= init_entry(tbl_idx);
                        tbl_idx  <= tbl_idx + 4'd1;
                        byte_idx <= 2'd0;
                        state    <= S_START;
                    end else begin
                        cfg.done <= 1'b1;
                        cfg.busy <= 1'b0;
                        walking  <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
